mc_interp4: RTL
===============

Name: mc_interp4

Overview:
- Rate-expanding counterpart to the team's 4-tap sum-of-products averaging filter.
- Accepts one signed sample per input handshake and emits PHASES linearly interpolated signed samples per input, through a valid/ready stream.
- Sits between a low-rate sample producer and the full-rate filter datapath, so `io_out` feeds a filter's `io_x`.
- Output lags input by one input sample: it interpolates from the previous sample toward the current one.

Parameters:
- WIDTH, 16, sample width (two's complement), in and out.
- PHASES, 4, output samples per input sample; power of two, at least 2.
- LOG2_PHASES, 2, log2(PHASES); sets the phase counter width and the shift amount.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- io_in_valid  input  1  producer presents a sample.
- io_in_ready  output  1  block accepts the sample this cycle.
- io_in_bits  input  WIDTH  signed input sample.
- io_out_valid  output  1  interpolated sample present.
- io_out_ready  input  1  consumer takes the sample this cycle.
- io_out_bits  output  WIDTH  signed interpolated sample.

Behaviour:
- Registers:
  - `prev`, `cur`: WIDTH, signed.
  - `phase`: LOG2_PHASES bits, unsigned.
  - `state`: IDLE or RUN.
- Reset (reset=0, takes effect immediately, asynchronous): `prev`=0, `cur`=0, `phase`=0, `state`=IDLE.
  - `io_out_valid`=0 and `io_in_ready`=1 while in reset.
  - A reset mid-burst discards remaining phases; no partial output after release.
- Handshakes:
  - Input accept: `io_in_valid & io_in_ready`.
  - Output transfer: `io_out_valid & io_out_ready`.
- `io_in_ready` = (state==IDLE) OR (state==RUN AND phase==PHASES-1 AND io_out_ready).
- `io_out_valid` = (state==RUN). `io_out_bits` is combinational from registers only; no input-to-output combinational path.
- On input accept: `prev`<=`cur`, `cur`<=`io_in_bits`, `phase`<=0, `state`<=RUN.
  - First interpolated output is valid the cycle after accept (latency 1).
- On output transfer with phase<PHASES-1: `phase`<=`phase`+1.
- On output transfer with phase==PHASES-1:
  - Simultaneous input accept: load per the input-accept rule and stay in RUN. This gives zero bubbles, so sustained throughput is one output per cycle.
  - No input accept: `state`<=IDLE, `phase`<=0.
- While io_out_ready=0 in RUN, all registers and `io_out_bits` are held stable (AXI-style: valid never drops without a transfer).
- Arithmetic:
  - d = cur - prev, computed in WIDTH+1 signed bits.
  - p = d * phase, in WIDTH+1+LOG2_PHASES signed bits; phase is zero-extended, non-negative.
  - q = p >>> LOG2_PHASES (arithmetic shift, floor rounding).
  - `io_out_bits` = prev + q, truncated to WIDTH.
  - The result always lies in [min(prev,cur), max(prev,cur)], so truncation never overflows.
- Phase-0 output equals `prev` exactly. After reset, the first burst ramps from 0.
- `io_in_bits` is ignored when not accepted. `io_out_ready` is ignored in IDLE.

Test Plan:
1. Reset, then accept 400 with io_out_ready=1 -> io_out_bits 0,100,200,300 on four consecutive cycles, then IDLE with io_in_ready=1.
2. Back-to-back inputs 400, -400 with io_in_valid held high and io_out_ready=1 -> outputs 0,100,200,300,400,200,0,-200 with no gap cycles. io_in_ready pulses only on the phase-3 cycles.
3. Backpressure: accept 400 after prior input 0, then hold io_out_ready=0 for 5 cycles during phase 1 -> io_out_valid stays 1, io_out_bits stays 100, phase does not advance. Release -> 200,300 follow.
4. Extremes: prev=-32768, cur=32767 -> -32768,-16385,-1,16383, with no wraparound. Then cur=-32768 -> 32767,16383,-1,-16385.
5. Floor rounding: prev=0, cur=-1 -> 0,-1,-1,-1. prev=0, cur=3 -> 0,0,1,2.
6. Reset asserted asynchronously between clock edges at phase 2 -> io_out_valid drops immediately. After release, io_in_ready=1, and the next input 80 yields 0,20,40,60 (prev cleared to 0).

Source files
------------

// File: rtl/mc_interp4.sv
// Linear interpolator: expands each accepted signed sample into PHASES outputs
// that ramp from the previous sample toward the current one, over a valid/ready stream.
module mc_interp4 #(
  parameter int WIDTH       = 16,
  parameter int PHASES      = 4,
  parameter int LOG2_PHASES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits
);

  localparam int PW = WIDTH + 1 + LOG2_PHASES;
  localparam logic [LOG2_PHASES-1:0] LAST_PHASE = LOG2_PHASES'(PHASES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state, state_nxt;
  logic signed [WIDTH-1:0]  prev, prev_nxt;
  logic signed [WIDTH-1:0]  cur, cur_nxt;
  logic [LOG2_PHASES-1:0]   phase, phase_nxt;

  logic in_acc, out_xfer, last;

  assign last         = (phase == LAST_PHASE);
  assign io_out_valid = (state == RUN);
  assign io_in_ready  = (state == IDLE) || ((state == RUN) && last && io_out_ready);
  assign in_acc       = io_in_valid && io_in_ready;
  assign out_xfer     = io_out_valid && io_out_ready;

  // Interpolation datapath: registers only, so no input-to-output path.
  logic signed [WIDTH:0]  diff;
  logic signed [PW-1:0]   prod, quot, sum;

  assign diff = $signed({cur[WIDTH-1], cur}) - $signed({prev[WIDTH-1], prev});
  assign prod = PW'(diff) * $signed({{(PW-LOG2_PHASES){1'b0}}, phase});
  assign quot = prod >>> LOG2_PHASES;
  assign sum  = PW'(prev) + quot;
  // Result lies between prev and cur, so dropping the top bits cannot overflow.
  assign io_out_bits = sum[WIDTH-1:0];

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latches).
    state_nxt = state;
    prev_nxt  = prev;
    cur_nxt   = cur;
    phase_nxt = phase;
    if (in_acc) begin
      prev_nxt  = cur;
      cur_nxt   = $signed(io_in_bits);
      phase_nxt = '0;
      state_nxt = RUN;
    end else if (out_xfer) begin
      if (last) begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end else begin
        phase_nxt = phase + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      prev  <= '0;
      cur   <= '0;
      phase <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      state <= state_nxt;
      prev  <= prev_nxt;
      cur   <= cur_nxt;
      phase <= phase_nxt;
    end
  end

endmodule
